cdu_count_scheduler: RTL and testbench
======================================

CDU_COUNT_SCHEDULER -- requirements
Module: cdu_count_scheduler

Interface
REQ-001 SHALL have parameter CNTW, default 4, giving the signed width of each per-axis pending-count accumulator (allowed range 3..8).
REQ-002 SHALL have parameter TMO, default 15, giving the number of cycles to wait for CNT_ACK before abandoning a request (allowed range 2..255).
REQ-003 SHALL have ports:
  clk  in  1  single clock; all state changes on its rising edge
  rst  in  1  synchronous reset, active-high
  FAZ2HI  in  1  one-cycle strobe that opens a count slot
  AUP/ADN, BUP/BDN, CUP/CDN  in  1 each  one-cycle plus/minus count pulses for axes A, B, C
  ISSZ  in  1  zero command; level-sensitive
  DMMCA  in  1  coarse-align inhibit; level-sensitive
  CNT_ACK  in  1  counter-cycle acknowledge
  CNT_REQ  out  1  count request
  CNT_AXIS  out  2  requesting axis: 1=A, 2=B, 3=C, 0=none
  CNT_SIGN  out  1  count sign: 0=plus, 1=minus
  BUSY  out  1  high in any FSM state other than IDLE
  OVF  out  3  sticky saturation flags; bit0=A, bit1=B, bit2=C
  TMO_ERR  out  1  sticky acknowledge-timeout flag
REQ-004 SHALL use one clock domain; reset is synchronous and active-high.

Function
REQ-005 SHALL keep one signed CNTW-bit accumulator per axis; each cycle its next value = current + UP - DN - grant_adjust + restore.
REQ-006 SHALL apply no net change to an accumulator when its UP and DN pulses arrive in the same cycle.
REQ-007 SHALL saturate each accumulator at +(2^(CNTW-1)-1) and -(2^(CNTW-1)); an increment clipped by saturation SHALL set that axis's OVF bit.
REQ-008 SHALL define grant_adjust: +1 when a plus count is granted on that axis, -1 when a minus count is granted, so a grant always moves the accumulator one step toward zero.
REQ-009 SHALL implement FSM states IDLE, WAIT, GAP.
REQ-010 IDLE: when FAZ2HI=1, DMMCA=0, ISSZ=0 and any accumulator is nonzero, SHALL grant exactly one axis and go to WAIT.
REQ-011 SHALL choose the granted axis by round-robin among axes with nonzero accumulators, starting from the axis after the last one granted.
REQ-012 On a grant, next cycle SHALL show CNT_REQ=1, CNT_AXIS=axis, CNT_SIGN=1 if the accumulator was negative; these outputs SHALL stay stable through WAIT.
REQ-013 WAIT: when CNT_ACK=1, SHALL go to GAP; CNT_REQ SHALL be 0 from the next cycle.
REQ-014 WAIT: if TMO cycles pass with no CNT_ACK, SHALL go to IDLE, drop CNT_REQ, set TMO_ERR, and restore the count to the accumulator (restore = -grant_adjust, saturating).
REQ-015 GAP: SHALL last exactly one cycle with CNT_REQ=0 and CNT_AXIS=0, then return to IDLE; this limits output to one count per slot.
REQ-016 CNT_ACK SHALL have no effect outside WAIT.
REQ-017 ISSZ=1 SHALL clear all accumulators and OVF each cycle it is high, override any same-cycle pulses, and block new grants; an in-flight WAIT SHALL still complete normally and a timeout restore under ISSZ SHALL be discarded.
REQ-018 DMMCA=1 SHALL block new grants only; accumulation and in-flight requests SHALL continue.
REQ-019 A FAZ2HI strobe arriving in WAIT or GAP SHALL be ignored, not queued.
REQ-020 OVF and TMO_ERR SHALL clear only on rst; in addition, ISSZ clears OVF.

Reset
REQ-021 rst SHALL force: FSM=IDLE; accumulators=0; CNT_REQ=0; CNT_AXIS=0; CNT_SIGN=0; BUSY=0; OVF=0; TMO_ERR=0; round-robin pointer set so the first grant goes to A.
REQ-022 rst asserted during WAIT SHALL drop CNT_REQ the following cycle, with no restore and no TMO_ERR.

Verification
REQ-023 Three AUP pulses, then FAZ2HI every 8 cycles, with CNT_ACK 2 cycles after each CNT_REQ -> three requests, each AXIS=1 and SIGN=0; accumulator A ends at 0.
REQ-024 AUP, BDN and CUP pending together, then slots -> grant order A(+), B(-), C(+), with A taken again only after C.
REQ-025 Nine AUP pulses with CNTW=4 -> accumulator A=7 and OVF=001; then ISSZ for 1 cycle -> accumulators=0 and OVF=000.
REQ-026 One BDN pending, grant issued, CNT_ACK withheld -> CNT_REQ drops after 15 cycles, TMO_ERR=1, accumulator B=-1, next slot re-requests B with SIGN=1.
REQ-027 DMMCA=1 with CUP pending and a slot strobe -> no CNT_REQ; DMMCA released, next slot -> AXIS=3.
REQ-028 AUP and ADN in the same cycle, then a slot -> accumulator A=0 and no request.

Source files
------------

// File: rtl/cdu_count_scheduler.sv
// Count-slot scheduler: accumulates per-axis plus/minus pulses and issues one
// counter-cycle request per FAZ2HI slot, round-robin across axes A/B/C.
module cdu_count_scheduler #(
  parameter int CNTW = 4,
  parameter int TMO  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FAZ2HI,
  input  logic              AUP,
  input  logic              ADN,
  input  logic              BUP,
  input  logic              BDN,
  input  logic              CUP,
  input  logic              CDN,
  input  logic              ISSZ,
  input  logic              DMMCA,
  input  logic              CNT_ACK,
  output logic              CNT_REQ,
  output logic [1:0]        CNT_AXIS,
  output logic              CNT_SIGN,
  output logic              BUSY,
  output logic [2:0]        OVF,
  output logic              TMO_ERR,
  output logic [1:0]        dbg_state,
  output logic [3*CNTW-1:0] dbg_acc
);

  // Request handshake: CNT_REQ rises the cycle after a grant and holds with
  // CNT_AXIS/CNT_SIGN stable until the first cycle CNT_ACK is seen high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int AMAX = (1 << (CNTW - 1)) - 1;
  localparam int AMIN = -(1 << (CNTW - 1));
  localparam logic signed [CNTW+1:0] WMAX = (CNTW + 2)'(AMAX);
  localparam logic signed [CNTW+1:0] WMIN = (CNTW + 2)'(AMIN);
  localparam logic signed [CNTW+1:0] ONE  = (CNTW + 2)'(1);
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t state, state_n;
  logic signed [CNTW-1:0] acc   [3];
  logic signed [CNTW-1:0] acc_n [3];
  logic signed [CNTW+1:0] sum   [3];
  logic [2:0] up, dn, nz, clip;
  logic [1:0] last_axis, req_axis, rr_start, grant_idx;
  logic [2:0] cand;
  logic       req_sign, found, can_grant, timeout;
  logic [7:0] tmo_cnt;

  assign up = {CUP, BUP, AUP};
  assign dn = {CDN, BDN, ADN};

  always_comb begin
    for (int i = 0; i < 3; i++) nz[i] = (acc[i] != '0);
  end

  assign can_grant = (state == S_IDLE) && FAZ2HI && !DMMCA && !ISSZ && (|nz);

  // Search starts at the axis after the last grant; last_axis holds 1..3.
  always_comb begin
    rr_start  = (last_axis == 2'd3) ? 2'd0 : last_axis;
    grant_idx = 2'd0;
    found     = 1'b0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_start} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && nz[cand[1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      S_IDLE: if (can_grant) state_n = S_WAIT;
      S_WAIT: begin
        if (CNT_ACK) begin
          state_n = S_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_GAP:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Grants step toward zero; a timeout undoes the step of the abandoned grant.
  always_comb begin
    clip = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = {{2{acc[i][CNTW-1]}}, acc[i]};
      if (up[i]) sum[i] = sum[i] + ONE;
      if (dn[i]) sum[i] = sum[i] - ONE;
      if (can_grant && grant_idx == 2'(i))
        sum[i] = acc[i][CNTW-1] ? sum[i] + ONE : sum[i] - ONE;
      if (timeout && req_axis == 2'(i + 1))
        sum[i] = req_sign ? sum[i] - ONE : sum[i] + ONE;
      clip[i] = (sum[i] > WMAX) || (sum[i] < WMIN);
      if (sum[i] > WMAX)      acc_n[i] = WMAX[CNTW-1:0];
      else if (sum[i] < WMIN) acc_n[i] = WMIN[CNTW-1:0];
      else                    acc_n[i] = sum[i][CNTW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      for (int i = 0; i < 3; i++) acc[i] <= '0;
      last_axis <= 2'd3;
      req_axis  <= 2'd0;
      req_sign  <= 1'b0;
      tmo_cnt   <= 8'd0;
      OVF       <= 3'b000;
      TMO_ERR   <= 1'b0;
    end else begin
      state <= state_n;
      for (int i = 0; i < 3; i++) acc[i] <= ISSZ ? '0 : acc_n[i];
      OVF <= ISSZ ? 3'b000 : (OVF | clip);
      if (timeout) TMO_ERR <= 1'b1;
      if (can_grant) begin
        req_axis  <= grant_idx + 2'd1;
        req_sign  <= acc[grant_idx][CNTW-1];
        last_axis <= grant_idx + 2'd1;
        tmo_cnt   <= 8'd0;
      end else if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  assign CNT_REQ   = (state == S_WAIT);
  assign CNT_AXIS  = CNT_REQ ? req_axis : 2'd0;
  assign CNT_SIGN  = CNT_REQ & req_sign;
  assign BUSY      = (state != S_IDLE);
  assign dbg_state = state;
  assign dbg_acc   = {acc[2], acc[1], acc[0]};

endmodule

// File: tb/tb_cdu_count_scheduler.sv
// Bench for cdu_count_scheduler: vector table, directed multi-cycle sequences,
// and randomized traffic compared against an integer reference model.
module tb_cdu_count_scheduler;

  localparam int CNTW = 4;
  localparam int TMO  = 15;
  localparam int AMAX = (1 << (CNTW - 1)) - 1;
  localparam int AMIN = -(1 << (CNTW - 1));

  logic clk, rst, FAZ2HI, AUP, ADN, BUP, BDN, CUP, CDN, ISSZ, DMMCA, CNT_ACK;
  logic CNT_REQ, CNT_SIGN, BUSY, TMO_ERR;
  logic [1:0] CNT_AXIS, dbg_state;
  logic [2:0] OVF;
  logic [3*CNTW-1:0] dbg_acc;

  int checks = 0;
  int errors = 0;

  cdu_count_scheduler #(.CNTW(CNTW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .FAZ2HI(FAZ2HI),
    .AUP(AUP), .ADN(ADN), .BUP(BUP), .BDN(BDN), .CUP(CUP), .CDN(CDN),
    .ISSZ(ISSZ), .DMMCA(DMMCA), .CNT_ACK(CNT_ACK),
    .CNT_REQ(CNT_REQ), .CNT_AXIS(CNT_AXIS), .CNT_SIGN(CNT_SIGN), .BUSY(BUSY),
    .OVF(OVF), .TMO_ERR(TMO_ERR), .dbg_state(dbg_state), .dbg_acc(dbg_acc)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: integer accumulators plus an outstanding-request record
  int m_acc[3];
  bit [2:0] m_ovf;
  bit m_tmo_err, m_sign, m_gap;
  int m_axis, m_left, m_last;

  task automatic model_step();
    int nxt[3];
    int g;
    bit [2:0] u, d;
    if (rst) begin
      m_acc = '{0, 0, 0}; m_ovf = 3'b000; m_tmo_err = 0; m_axis = 0;
      m_sign = 0; m_left = 0; m_gap = 0; m_last = 3;
      return;
    end
    u = {CUP, BUP, AUP};
    d = {CDN, BDN, ADN};
    for (int i = 0; i < 3; i++) nxt[i] = m_acc[i] + int'(u[i]) - int'(d[i]);
    if (m_axis != 0) begin
      if (CNT_ACK) begin
        m_axis = 0;
        m_gap  = 1;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          nxt[m_axis-1] += m_sign ? -1 : 1;
          m_tmo_err = 1;
          m_axis = 0;
        end
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (FAZ2HI && !DMMCA && !ISSZ &&
                 (m_acc[0] != 0 || m_acc[1] != 0 || m_acc[2] != 0)) begin
      g = 0;
      for (int k = 1; k <= 3; k++) begin
        int ax;
        ax = (m_last - 1 + k) % 3 + 1;
        if (g == 0 && m_acc[ax-1] != 0) g = ax;
      end
      m_sign = (m_acc[g-1] < 0);
      nxt[g-1] += m_sign ? 1 : -1;
      m_axis = g;
      m_left = TMO;
      m_last = g;
    end
    for (int i = 0; i < 3; i++) begin
      if (nxt[i] > AMAX) begin nxt[i] = AMAX; m_ovf[i] = 1; end
      else if (nxt[i] < AMIN) begin nxt[i] = AMIN; m_ovf[i] = 1; end
      m_acc[i] = nxt[i];
    end
    if (ISSZ) begin
      m_acc = '{0, 0, 0};
      m_ovf = 3'b000;
    end
  endtask

  // driver tasks
  task automatic clr_inputs();
    FAZ2HI = 0; AUP = 0; ADN = 0; BUP = 0; BDN = 0; CUP = 0; CDN = 0;
    ISSZ = 0; DMMCA = 0; CNT_ACK = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic set_pulses(input bit [2:0] u, input bit [2:0] d);
    {CUP, BUP, AUP} = u;
    {CDN, BDN, ADN} = d;
  endtask

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int acc_of(input int i);
    logic signed [CNTW-1:0] v;
    v = dbg_acc[i*CNTW +: CNTW];
    return int'(v);
  endfunction

  task automatic check_model();
    chk("rnd_req",  int'(CNT_REQ),  int'(m_axis != 0));
    chk("rnd_axis", int'(CNT_AXIS), m_axis);
    chk("rnd_sign", int'(CNT_SIGN), int'(m_axis != 0 && m_sign));
    chk("rnd_busy", int'(BUSY),     int'(m_axis != 0 || m_gap));
    chk("rnd_ovf",  int'(OVF),      int'(m_ovf));
    chk("rnd_tmo",  int'(TMO_ERR),  int'(m_tmo_err));
    chk("rnd_acc_a", acc_of(0), m_acc[0]);
    chk("rnd_acc_b", acc_of(1), m_acc[1]);
    chk("rnd_acc_c", acc_of(2), m_acc[2]);
  endtask

  typedef struct {
    int faz, up, dn, issz, dmmca, ack;
    int req, axis, sign, busy, a, b, c;
  } vec_t;

  function automatic vec_t mk(input int faz, input int up, input int dn, input int issz,
                              input int dmmca, input int ack, input int req, input int axis,
                              input int sign, input int busy, input int a, input int b,
                              input int c);
    vec_t v;
    v = '{faz, up, dn, issz, dmmca, ack, req, axis, sign, busy, a, b, c};
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    int age, nreq, hi, ack_pct;
    bit dm;
    // up/dn fields are {C,B,A}
    tbl[0]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0, 0);
    tbl[1]  = mk(0, 0, 2, 0, 0, 0,  0, 0, 0, 0,  1, -1, 0);
    tbl[2]  = mk(0, 4, 0, 0, 0, 0,  0, 0, 0, 0,  1, -1, 1);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 1,  0, -1, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 1,  0, -1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1,  0, -1, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, -1, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0,  1, 2, 1, 1,  0,  0, 1);
    tbl[8]  = mk(0, 1, 0, 0, 0, 1,  0, 0, 0, 1,  1,  0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0, 1);
    tbl[10] = mk(1, 0, 0, 0, 0, 0,  1, 3, 0, 1,  1,  0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1,  1,  0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1,  0, 0);
    tbl[13] = mk(1, 0, 0, 0, 1, 0,  0, 0, 0, 0,  1,  0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 1,  0,  0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 1,  0,  0, 0);
    tbl[16] = mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  0,  0, 0);
    tbl[17] = mk(0, 1, 1, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0,  0, 0);

    clr_inputs();
    rst = 1;
    tick();
    tick();
    chk("rst_req",  int'(CNT_REQ),  0);
    chk("rst_axis", int'(CNT_AXIS), 0);
    chk("rst_sign", int'(CNT_SIGN), 0);
    chk("rst_busy", int'(BUSY),     0);
    chk("rst_ovf",  int'(OVF),      0);
    chk("rst_tmo",  int'(TMO_ERR),  0);
    chk("rst_acc_a", acc_of(0), 0);
    rst = 0;

    for (int r = 0; r < 19; r++) begin
      clr_inputs();
      FAZ2HI = tbl[r].faz[0];
      set_pulses(3'(tbl[r].up), 3'(tbl[r].dn));
      ISSZ = tbl[r].issz[0];
      DMMCA = tbl[r].dmmca[0];
      CNT_ACK = tbl[r].ack[0];
      tick();
      chk($sformatf("tbl%0d_req", r),  int'(CNT_REQ),  tbl[r].req);
      chk($sformatf("tbl%0d_axis", r), int'(CNT_AXIS), tbl[r].axis);
      chk($sformatf("tbl%0d_sign", r), int'(CNT_SIGN), tbl[r].sign);
      chk($sformatf("tbl%0d_busy", r), int'(BUSY),     tbl[r].busy);
      chk($sformatf("tbl%0d_a", r), acc_of(0), tbl[r].a);
      chk($sformatf("tbl%0d_b", r), acc_of(1), tbl[r].b);
      chk($sformatf("tbl%0d_c", r), acc_of(2), tbl[r].c);
      chk($sformatf("tbl%0d_ovf", r), int'(OVF), 0);
    end
    clr_inputs();

    // three pending plus counts drained one per 8-cycle slot, ack two cycles in
    do_reset();
    for (int i = 0; i < 3; i++) begin AUP = 1; tick(); end
    clr_inputs();
    age = 0;
    nreq = 0;
    for (int c = 0; c < 32; c++) begin
      if (CNT_REQ) age++; else age = 0;
      if (age == 1) begin
        nreq++;
        chk("slot_axis", int'(CNT_AXIS), 1);
        chk("slot_sign", int'(CNT_SIGN), 0);
      end
      clr_inputs();
      FAZ2HI = (c % 8 == 0);
      CNT_ACK = (age == 3);
      tick();
    end
    chk("slot_nreq", nreq, 3);
    chk("slot_acc_a", acc_of(0), 0);

    // saturation then zero command
    do_reset();
    for (int i = 0; i < 9; i++) begin AUP = 1; tick(); end
    clr_inputs();
    tick();
    chk("sat_acc_a", acc_of(0), 7);
    chk("sat_ovf", int'(OVF), 1);
    ISSZ = 1;
    tick();
    ISSZ = 0;
    chk("issz_acc_a", acc_of(0), 0);
    chk("issz_ovf", int'(OVF), 0);

    // acknowledge withheld: timeout, restore, re-request with minus sign
    do_reset();
    BDN = 1;
    tick();
    clr_inputs();
    FAZ2HI = 1;
    tick();
    clr_inputs();
    chk("tmo_req_axis", int'(CNT_AXIS), 2);
    chk("tmo_req_sign", int'(CNT_SIGN), 1);
    chk("tmo_grant_b", acc_of(1), 0);
    hi = 0;
    while (CNT_REQ && hi < 40) begin
      hi++;
      tick();
    end
    chk("tmo_req_cycles", hi, TMO);
    chk("tmo_err", int'(TMO_ERR), 1);
    chk("tmo_restore_b", acc_of(1), -1);
    FAZ2HI = 1;
    tick();
    clr_inputs();
    chk("tmo_rereq_axis", int'(CNT_AXIS), 2);
    chk("tmo_rereq_sign", int'(CNT_SIGN), 1);
    CNT_ACK = 1;
    tick();
    clr_inputs();
    chk("tmo_ack_req", int'(CNT_REQ), 0);
    chk("tmo_err_sticky", int'(TMO_ERR), 1);

    // reset during WAIT
    do_reset();
    AUP = 1;
    tick();
    clr_inputs();
    FAZ2HI = 1;
    tick();
    clr_inputs();
    chk("rstw_req_before", int'(CNT_REQ), 1);
    rst = 1;
    tick();
    chk("rstw_req", int'(CNT_REQ), 0);
    chk("rstw_tmo", int'(TMO_ERR), 0);
    chk("rstw_acc_a", acc_of(0), 0);
    rst = 0;

    // ISSZ held over an in-flight request that times out: restore discarded
    do_reset();
    CUP = 1;
    tick();
    clr_inputs();
    FAZ2HI = 1;
    tick();
    clr_inputs();
    ISSZ = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("isszw_req_held", int'(CNT_REQ), 1);
    chk("isszw_axis_held", int'(CNT_AXIS), 3);
    for (int i = 0; i < TMO; i++) tick();
    chk("isszw_req_drop", int'(CNT_REQ), 0);
    chk("isszw_tmo", int'(TMO_ERR), 1);
    chk("isszw_acc_c", acc_of(2), 0);
    clr_inputs();

    // randomized traffic against the model
    do_reset();
    dm = 0;
    ack_pct = 30;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(2))
          0: ack_pct = 0;
          1: ack_pct = 25;
          default: ack_pct = 60;
        endcase
      end
      if ($urandom_range(15) == 0) dm = ~dm;
      FAZ2HI = ($urandom_range(3) == 0);
      AUP = ($urandom_range(2) == 0);
      ADN = ($urandom_range(2) == 0);
      BUP = ($urandom_range(2) == 0);
      BDN = ($urandom_range(3) == 0);
      CUP = ($urandom_range(4) == 0);
      CDN = ($urandom_range(2) == 0);
      ISSZ = ($urandom_range(39) == 0);
      DMMCA = dm;
      CNT_ACK = ($urandom_range(99) < ack_pct);
      rst = ($urandom_range(499) == 0);
      tick();
      check_model();
    end
    rst = 0;
    clr_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
